// File: rtl/sumador_pkg.sv
// ============================================================================
//  Module      : sumador_pkg
//  Description : Shared definitions for the serial adder: FSM state
//                encodings and the counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sumador_pkg;

   // FSM state encodings
   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      CALCULO = 2'd1,
      FIN     = 2'd2
   } estado_t;

   // Bits needed to count n steps (0 .. n-1), never less than one bit
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sumador_completo.sv
// ============================================================================
//  Module      : sumador_completo
//  Description : 1-bit full adder, one link of the ripple chain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sumador_completo (
   input  logic a_i,
   input  logic b_i,
   input  logic acarreo_i,
   output logic suma_o,
   output logic acarreo_o
);

   assign suma_o    = a_i ^ b_i ^ acarreo_i;
   assign acarreo_o = (a_i & b_i) | (acarreo_i & (a_i ^ b_i));

endmodule

`default_nettype wire

// File: rtl/sumador_serie.sv
// ============================================================================
//  Module      : sumador_serie
//  Description : Multi-cycle adder for ANCHO-bit unsigned operands,
//                BITS_POR_CICLO bits per clock through a short ripple chain
//                with a registered carry between steps. Start/done handshake.
//                Optional macro SUMADOR_SERIE_RESTA_EN adds the i_resta port
//                (two's-complement subtraction, o_acarreo = no borrow).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sumador_serie
   import sumador_pkg::*;
#(
   parameter int ANCHO          = 8,
   parameter int BITS_POR_CICLO = 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_inicio,
   input  logic [ANCHO-1:0] i_operando_a,
   input  logic [ANCHO-1:0] i_operando_b,
`ifdef SUMADOR_SERIE_RESTA_EN
   input  logic             i_resta,
`endif
   output logic             o_ocupado,
   output logic             o_fin,
   output logic [ANCHO-1:0] o_suma,
   output logic             o_acarreo
);

   localparam int             PASOS  = ANCHO / BITS_POR_CICLO;
   localparam int             CW     = clog2_min1(PASOS);
   localparam logic [CW-1:0]  ULTIMO = CW'(PASOS - 1);

   // Reject widths the step slicing cannot cover exactly
   generate
      if ((ANCHO < 1) || (BITS_POR_CICLO < 1) || ((ANCHO % BITS_POR_CICLO) != 0)) begin : g_param_error
         $error("sumador_serie: BITS_POR_CICLO must divide ANCHO");
      end
   endgenerate

   estado_t                   estado_q;
   logic [ANCHO-1:0]          a_q, b_q, acc_q, suma_q;
   logic                      carry_q, acarreo_q, ocupado_q, fin_q;
   logic [CW-1:0]             cnt_q;

   logic [BITS_POR_CICLO-1:0] parcial_d;
   logic [BITS_POR_CICLO:0]   cadena_d;
   logic [ANCHO-1:0]          acc_d;
   logic [ANCHO-1:0]          b_carga_d;
   logic                      carry_carga_d;

   // Operand B and initial carry as loaded on an accepted start
`ifdef SUMADOR_SERIE_RESTA_EN
   assign b_carga_d     = i_resta ? ~i_operando_b : i_operando_b;
   assign carry_carga_d = i_resta;
`else
   assign b_carga_d     = i_operando_b;
   assign carry_carga_d = 1'b0;
`endif

   // Ripple chain over the low BITS_POR_CICLO bits, fed by the stored carry
   assign cadena_d[0] = carry_q;
   generate
      for (genvar i = 0; i < BITS_POR_CICLO; i++) begin : g_bit
         sumador_completo u_fa (
            .a_i       (a_q[i]),
            .b_i       (b_q[i]),
            .acarreo_i (cadena_d[i]),
            .suma_o    (parcial_d[i]),
            .acarreo_o (cadena_d[i+1])
         );
      end
   endgenerate

   // Partial sum enters the accumulator from the MSB side
   assign acc_d = (acc_q >> BITS_POR_CICLO)
                | (ANCHO'(parcial_d) << (ANCHO - BITS_POR_CICLO));

   // Control FSM and datapath; result registers change only on the last step
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         estado_q  <= REPOSO;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         suma_q    <= '0;
         carry_q   <= 1'b0;
         acarreo_q <= 1'b0;
         ocupado_q <= 1'b0;
         fin_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         case (estado_q)
            REPOSO: begin
               if (i_inicio) begin
                  a_q       <= i_operando_a;
                  b_q       <= b_carga_d;
                  carry_q   <= carry_carga_d;
                  acc_q     <= '0;
                  cnt_q     <= '0;
                  ocupado_q <= 1'b1;
                  estado_q  <= CALCULO;
               end
            end
            CALCULO: begin
               a_q     <= a_q >> BITS_POR_CICLO;
               b_q     <= b_q >> BITS_POR_CICLO;
               acc_q   <= acc_d;
               carry_q <= cadena_d[BITS_POR_CICLO];
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == ULTIMO) begin
                  suma_q    <= acc_d;
                  acarreo_q <= cadena_d[BITS_POR_CICLO];
                  fin_q     <= 1'b1;
                  estado_q  <= FIN;
               end
            end
            FIN: begin
               fin_q     <= 1'b0;
               ocupado_q <= 1'b0;
               estado_q  <= REPOSO;
            end
            default: begin
               fin_q     <= 1'b0;
               ocupado_q <= 1'b0;
               estado_q  <= REPOSO;
            end
         endcase
      end
   end

   assign o_ocupado = ocupado_q;
   assign o_fin     = fin_q;
   assign o_suma    = suma_q;
   assign o_acarreo = acarreo_q;

endmodule

`default_nettype wire
